mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Next-generation multi-cycle MIPS control FSM. Drives the datapath's mux selects, memory strobes and PC/IR enables.
//  Adds a memory wait-state handshake (mem_ready), bne, an illegal-opcode trap state, and a retire pulse/counter.
//  Sits between the IR opcode field and the datapath. Feeds alu_op to the existing ALU controller.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter instr_count
//  MEM_WAIT_EN  1   1: memory states stall until mem_ready=1; 0: mem_ready ignored (treated as 1)
//  TRAP_EN      1   1: illegal opcode -> TRAP (sticky); 0: illegal opcode -> IF (executes as NOP)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  opcode       in   6      IR[31:26]; datapath holds it stable from ID until retire
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory completed access this cycle
//  reg_dst      out  2      00 rt, 01 rd, 10 $31
//  mem_to_reg   out  2      00 ALUout, 01 MDR, 10 PC
//  reg_write    out  1      register file write enable
//  mem_read     out  1      memory read strobe
//  mem_write    out  1      memory write strobe
//  lord         out  1      0 address=PC, 1 address=ALUout
//  ir_write     out  1      IR load enable
//  alu_srca     out  1      0 PC, 1 A
//  alu_srcb     out  2      00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op       out  2      00 add, 01 sub, 10 func-decoded, 11 slt
//  pc_src       out  2      00 ALU result, 01 ALUout, 10 jump target, 11 A (jr)
//  pc_write_en  out  1      PC load enable (unconditional OR branch-qualified)
//  trap         out  1      high while in TRAP
//  retire       out  1      one-cycle pulse on the last cycle of each instruction
//  instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: rst=1 at an edge -> state IF, instr_count 0. While rst=1, every output is forced to 0.
//  - Outputs are decoded from state (Moore). Exceptions: ir_write/pc_write_en/retire are also qualified by mem_ready or zero, as listed.
//  - Let rdy = MEM_WAIT_EN ? mem_ready : 1. Outputs not listed for a state are 0.
//  - States and per-state outputs:
//    IF      mem_read, srcb=01, op=00, pc_src=00; ir_write=pc_write_en=rdy; stays in IF until rdy, then goes to ID.
//    ID      srcb=11, op=00. Next state by opcode:
//            000000->EXE, 100011/101011->MEMADR, 000100->BEQ, 000101->BNE, 000010->J, 000011->JAL,
//            000110->JR, 001001->ADDI, 001010->SLTI, other->TRAP (TRAP_EN=1) or IF (TRAP_EN=0).
//    MEMADR  srca, srcb=10, op=00; next state SW if opcode=101011, else MEMLW.
//    MEMLW   mem_read, lord; stays until rdy, then goes to LWWB.
//    LWWB    reg_write, reg_dst=00, mem_to_reg=01, retire; next state IF.
//    SW      mem_write, lord; stays until rdy; retire=rdy; next state IF when rdy.
//    EXE     srca, srcb=00, op=10; next state RTWB.
//    RTWB    reg_write, reg_dst=01, mem_to_reg=00, retire; next state IF.
//    BEQ     srca, srcb=00, op=01, pc_src=01, pc_write_en=zero, retire; next state IF.
//    BNE     same as BEQ but pc_write_en=~zero.
//    J       pc_write_en, pc_src=10, retire; next state IF.
//    JAL     pc_write_en, pc_src=10, reg_write, reg_dst=10, mem_to_reg=10, retire; next state IF.
//    JR      pc_write_en, pc_src=11, retire; next state IF.
//    ADDI    srca, srcb=10, op=00; next state ITWB.
//    SLTI    srca, srcb=10, op=11; next state ITWB.
//    ITWB    reg_write, reg_dst=00, mem_to_reg=00, retire; next state IF.
//    TRAP    trap=1, all else 0; sticky until rst. The NOP path (TRAP_EN=0) does not assert retire.
//  - Latency in cycles with no wait states: lw 5, sw 4, R/addi/slti 4, beq/bne/j/jal/jr 3. Each wait cycle adds 1.
//  - instr_count increments by 1 each cycle retire=1 and wraps modulo 2^CNT_W; it holds while in TRAP.
//  - mem_read/mem_write stay asserted and stable for the whole wait; lord does not change mid-access.
//  - Reset mid-access (rst during an IF/MEMLW/SW wait): the access is abandoned, there is no retire, and the next state is IF.
//  - Unreachable state encodings go to IF with all outputs 0.
// STRUCTURE
//  - Shared package mc_pkg holds the state enum, opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR,
//    OP_ADDI, OP_SLTI) and select encodings (ALUOP_*, SRCB_*, PCSRC_*, REGDST_*, M2R_*).
//  - One sub-module, mc_ctrl_decode: purely combinational state -> control-word decode.
//    The FSM register, next-state logic and counter stay in mc_ctrl_fsm.
// TESTING
//  1. Release rst with mem_ready=1 and run add (000000) -> IF,ID,EXE,RTWB: reg_dst=01 in RTWB, retire once, instr_count=1.
//  2. lw with mem_ready low for 2 cycles in IF and 3 in MEMLW -> lw takes 10 cycles.
//     ir_write pulses only once; mem_read stays high throughout; LWWB mem_to_reg=01.
//  3. beq with zero=1, then beq with zero=0, then bne with zero=0 -> pc_write_en = 1, 0, 1 in the branch state; pc_src=01.
//  4. jal -> JAL state: reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10, pc_write_en=1.
//  5. opcode 111111 with TRAP_EN=1 -> TRAP: trap=1 held for 20 cycles, count frozen; rst -> IF.
//     Same opcode with TRAP_EN=0 -> IF, no retire.
//  6. CNT_W=4: retire 17 instructions -> instr_count=1. Assert rst during an SW wait -> next state IF, count 0, no retire.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes, select encodings and control word for the multi-cycle controller
package mc_pkg;
  typedef enum logic [4:0] {
    S_IF, S_ID, S_MEMADR, S_MEMLW, S_LWWB, S_SW, S_EXE, S_RTWB,
    S_BEQ, S_BNE, S_J, S_JAL, S_JR, S_ADDI, S_SLTI, S_ITWB, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNC = 2'b10, ALUOP_SLT = 2'b11;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_JR = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       lord;
    logic       ir_write;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write_en;
    logic       trap;
    logic       retire;
  } ctl_t;
  function automatic state_t id_next(logic [5:0] op, logic trap_en);
    case (op)
      OP_RTYPE:     return S_EXE;
      OP_LW, OP_SW: return S_MEMADR;
      OP_BEQ:       return S_BEQ;
      OP_BNE:       return S_BNE;
      OP_J:         return S_J;
      OP_JAL:       return S_JAL;
      OP_JR:        return S_JR;
      OP_ADDI:      return S_ADDI;
      OP_SLTI:      return S_SLTI;
      default:      return trap_en ? S_TRAP : S_IF;
    endcase
  endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state to control-word decode
module mc_ctrl_decode import mc_pkg::*; (
  input  logic [4:0]               i_state,
  input  logic                     i_rdy,
  input  logic                     i_zero,
  output logic [$bits(ctl_t)-1:0]  o_ctl
);
  ctl_t w_c;
  assign o_ctl = w_c;
  always_comb begin
    w_c = '0;
    case (state_t'(i_state))
      S_IF: begin
        w_c.mem_read = 1'b1;
        w_c.alu_srcb = SRCB_4;
        w_c.alu_op = ALUOP_ADD;
        w_c.pc_src = PCSRC_ALU;
        w_c.ir_write = i_rdy;
        w_c.pc_write_en = i_rdy;
      end
      S_ID: w_c.alu_srcb = SRCB_BR;
      S_MEMADR: begin
        w_c.alu_srca = 1'b1;
        w_c.alu_srcb = SRCB_IMM;
      end
      S_MEMLW: begin
        w_c.mem_read = 1'b1;
        w_c.lord = 1'b1;
      end
      S_LWWB: begin
        w_c.reg_write = 1'b1;
        w_c.reg_dst = REGDST_RT;
        w_c.mem_to_reg = M2R_MDR;
        w_c.retire = 1'b1;
      end
      S_SW: begin
        w_c.mem_write = 1'b1;
        w_c.lord = 1'b1;
        w_c.retire = i_rdy;
      end
      S_EXE: begin
        w_c.alu_srca = 1'b1;
        w_c.alu_srcb = SRCB_B;
        w_c.alu_op = ALUOP_FUNC;
      end
      S_RTWB: begin
        w_c.reg_write = 1'b1;
        w_c.reg_dst = REGDST_RD;
        w_c.mem_to_reg = M2R_ALU;
        w_c.retire = 1'b1;
      end
      S_BEQ, S_BNE: begin
        w_c.alu_srca = 1'b1;
        w_c.alu_op = ALUOP_SUB;
        w_c.pc_src = PCSRC_ALUOUT;
        w_c.pc_write_en = (state_t'(i_state) == S_BEQ) ? i_zero : ~i_zero;
        w_c.retire = 1'b1;
      end
      S_J: begin
        w_c.pc_write_en = 1'b1;
        w_c.pc_src = PCSRC_JUMP;
        w_c.retire = 1'b1;
      end
      S_JAL: begin
        w_c.pc_write_en = 1'b1;
        w_c.pc_src = PCSRC_JUMP;
        w_c.reg_write = 1'b1;
        w_c.reg_dst = REGDST_RA;
        w_c.mem_to_reg = M2R_PC;
        w_c.retire = 1'b1;
      end
      S_JR: begin
        w_c.pc_write_en = 1'b1;
        w_c.pc_src = PCSRC_JR;
        w_c.retire = 1'b1;
      end
      S_ADDI, S_SLTI: begin
        w_c.alu_srca = 1'b1;
        w_c.alu_srcb = SRCB_IMM;
        w_c.alu_op = (state_t'(i_state) == S_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_ITWB: begin
        w_c.reg_write = 1'b1;
        w_c.reg_dst = REGDST_RT;
        w_c.mem_to_reg = M2R_ALU;
        w_c.retire = 1'b1;
      end
      S_TRAP: w_c.trap = 1'b1;
      default: w_c = '0;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with memory wait states, trap state and retire counter
module mc_ctrl_fsm import mc_pkg::*; #(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             lord,
  output logic             ir_write,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_write_en,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);
  state_t r_state, w_next;
  ctl_t w_ctl;
  logic w_rdy;
  logic [CNT_W-1:0] r_count;
  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  mc_ctrl_decode u_dec (
    .i_state(r_state),
    .i_rdy(w_rdy),
    .i_zero(zero),
    .o_ctl(w_ctl)
  );
  assign {reg_dst, mem_to_reg, reg_write, mem_read, mem_write, lord, ir_write, alu_srca,
          alu_srcb, alu_op, pc_src, pc_write_en, trap, retire} = rst ? '0 : w_ctl;
  assign instr_count = r_count;
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:           w_next = w_rdy ? S_ID : S_IF;
      S_ID:           w_next = id_next(opcode, TRAP_EN);
      S_MEMADR:       w_next = (opcode == OP_SW) ? S_SW : S_MEMLW;
      S_MEMLW:        w_next = w_rdy ? S_LWWB : S_MEMLW;
      S_SW:           w_next = w_rdy ? S_IF : S_SW;
      S_EXE:          w_next = S_RTWB;
      S_ADDI, S_SLTI: w_next = S_ITWB;
      S_TRAP:         w_next = S_TRAP;
      default:        w_next = S_IF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= r_count + CNT_W'(w_ctl.retire);
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized self-checking bench against a phase-level reference model
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  always #5 clk = ~clk;
  logic [1:0] rd_a, m2r_a, sb_a, ao_a, ps_a, rd_b, m2r_b, sb_b, ao_b, ps_b;
  logic rw_a, mr_a, mw_a, lo_a, irw_a, sa_a, pw_a, tr_a, rt_a;
  logic rw_b, mr_b, mw_b, lo_b, irw_b, sa_b, pw_b, tr_b, rt_b;
  logic [31:0] q_a;
  logic [3:0] q_b;
  logic [18:0] oa, ob, ea, eb;
  assign oa = {rd_a, m2r_a, rw_a, mr_a, mw_a, lo_a, irw_a, sa_a, sb_a, ao_a, ps_a, pw_a, tr_a, rt_a};
  assign ob = {rd_b, m2r_b, rw_b, mr_b, mw_b, lo_b, irw_b, sa_b, sb_b, ao_b, ps_b, pw_b, tr_b, rt_b};
  mc_ctrl_fsm #(.CNT_W(32), .MEM_WAIT_EN(1'b1), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .reg_dst(rd_a), .mem_to_reg(m2r_a), .reg_write(rw_a), .mem_read(mr_a), .mem_write(mw_a),
    .lord(lo_a), .ir_write(irw_a), .alu_srca(sa_a), .alu_srcb(sb_a), .alu_op(ao_a), .pc_src(ps_a),
    .pc_write_en(pw_a), .trap(tr_a), .retire(rt_a), .instr_count(q_a)
  );
  mc_ctrl_fsm #(.CNT_W(4), .MEM_WAIT_EN(1'b1), .TRAP_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .reg_dst(rd_b), .mem_to_reg(m2r_b), .reg_write(rw_b), .mem_read(mr_b), .mem_write(mw_b),
    .lord(lo_b), .ir_write(irw_b), .alu_srca(sa_b), .alu_srcb(sb_b), .alu_op(ao_b), .pc_src(ps_b),
    .pc_write_en(pw_b), .trap(tr_b), .retire(rt_b), .instr_count(q_b)
  );
  int vectors = 0, fails = 0;
  string ph_a = "", ph_b = "";
  logic [31:0] ma = '0;
  logic [3:0] mb = '0;
  function automatic string nxt(string p, logic [5:0] op, logic r, logic te);
    if (p == "IF") return r ? "ID" : "IF";
    if (p == "ID") begin
      case (op)
        6'h00: return "EXE";
        6'h23, 6'h2b: return "MEMADR";
        6'h04: return "BEQ";
        6'h05: return "BNE";
        6'h02: return "J";
        6'h03: return "JAL";
        6'h06: return "JR";
        6'h09: return "ADDI";
        6'h0a: return "SLTI";
        default: return te ? "TRAP" : "IF";
      endcase
    end
    if (p == "MEMADR") return (op == 6'h2b) ? "SW" : "MEMLW";
    if (p == "MEMLW") return r ? "LWWB" : "MEMLW";
    if (p == "SW") return r ? "IF" : "SW";
    if (p == "EXE") return "RTWB";
    if (p == "ADDI" || p == "SLTI") return "ITWB";
    if (p == "TRAP") return "TRAP";
    return "IF";
  endfunction
  function automatic logic [18:0] exp_ctl(string p, logic r, logic z);
    logic [1:0] rd = 0, m2r = 0, sb = 0, ao = 0, ps = 0;
    logic rw = 0, mr = 0, mw = 0, lo = 0, irw = 0, sa = 0, pw = 0, tr = 0, rt = 0;
    if (p == "IF") begin mr = 1; sb = 1; irw = r; pw = r; end
    if (p == "ID") sb = 3;
    if (p == "MEMADR") begin sa = 1; sb = 2; end
    if (p == "MEMLW") begin mr = 1; lo = 1; end
    if (p == "LWWB") begin rw = 1; m2r = 1; rt = 1; end
    if (p == "SW") begin mw = 1; lo = 1; rt = r; end
    if (p == "EXE") begin sa = 1; ao = 2; end
    if (p == "RTWB") begin rw = 1; rd = 1; rt = 1; end
    if (p == "BEQ") begin sa = 1; ao = 1; ps = 1; pw = z; rt = 1; end
    if (p == "BNE") begin sa = 1; ao = 1; ps = 1; pw = !z; rt = 1; end
    if (p == "J") begin pw = 1; ps = 2; rt = 1; end
    if (p == "JAL") begin pw = 1; ps = 2; rw = 1; rd = 2; m2r = 2; rt = 1; end
    if (p == "JR") begin pw = 1; ps = 3; rt = 1; end
    if (p == "ADDI") begin sa = 1; sb = 2; end
    if (p == "SLTI") begin sa = 1; sb = 2; ao = 3; end
    if (p == "ITWB") begin rw = 1; rt = 1; end
    if (p == "TRAP") tr = 1;
    return {rd, m2r, rw, mr, mw, lo, irw, sa, sb, ao, ps, pw, tr, rt};
  endfunction
  always_comb begin
    ea = rst ? 19'd0 : exp_ctl(ph_a, mem_ready, zero);
    eb = rst ? 19'd0 : exp_ctl(ph_b, mem_ready, zero);
  end
  always @(posedge clk) begin
    if (rst) begin
      ph_a <= "IF"; ph_b <= "IF"; ma <= '0; mb <= '0;
    end else begin
      ph_a <= nxt(ph_a, opcode, mem_ready, 1'b1);
      ph_b <= nxt(ph_b, opcode, mem_ready, 1'b0);
      ma <= ma + 32'(ea[0]);
      mb <= mb + 4'(eb[0]);
    end
  end
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      adv();
      opcode = 6'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      vectors += 2;
      if ({oa, q_a} !== 51'd0) begin fails++; $display("FAIL reset_a got=%h want=0", {oa, q_a}); end
      if ({ob, q_b} !== 23'd0) begin fails++; $display("FAIL reset_b got=%h want=0", {ob, q_b}); end
    end
  endtask
  task automatic test_add();
    adv();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) adv();
      opcode = 6'h00; zero = 1'($urandom); mem_ready = 1'b1;
      #1;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL add_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL add_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
      if (c == 3) begin
        vectors++;
        if ({rd_a, rt_a} !== 3'b011) begin fails++; $display("FAIL add_rtwb reg_dst/retire got=%b want=011", {rd_a, rt_a}); end
      end
    end
    adv();
    vectors++;
    if (q_a !== 32'd1) begin fails++; $display("FAIL add_count got=%0d want=1", q_a); end
  endtask
  task automatic test_lw();
    logic rs [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int irw = 0, rt_at = -1, mr_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) adv();
      opcode = 6'h23; zero = 1'($urandom); mem_ready = rs[c];
      #1;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL lw_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL lw_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
      irw += int'(irw_a);
      if (rt_a) rt_at = c;
      if ((c < 3 || (c >= 5 && c < 9)) && mr_a !== 1'b1) mr_bad++;
      if (c == 9) begin
        vectors++;
        if (m2r_a !== 2'b01) begin fails++; $display("FAIL lw_m2r got=%b want=01", m2r_a); end
      end
    end
    vectors += 3;
    if (irw != 1) begin fails++; $display("FAIL lw_irwrite pulses got=%0d want=1", irw); end
    if (rt_at != 9) begin fails++; $display("FAIL lw_latency retire_cycle got=%0d want=9", rt_at); end
    if (mr_bad != 0) begin fails++; $display("FAIL lw_memread dropped_cycles got=%0d want=0", mr_bad); end
    adv();
  endtask
  task automatic test_branch();
    logic [5:0] ops [3] = '{6'h04, 6'h04, 6'h05};
    logic zs [3] = '{1'b1, 1'b0, 1'b0};
    logic pws [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (c > 0) adv();
        opcode = ops[k]; zero = zs[k]; mem_ready = 1'b1;
        #1;
        vectors += 2;
        if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL br_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
        if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL br_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
        if (c == 2) begin
          vectors++;
          if ({pw_a, ps_a} !== {pws[k], 2'b01}) begin fails++; $display("FAIL br%0d pc_write_en/pc_src got=%b want=%b", k, {pw_a, ps_a}, {pws[k], 2'b01}); end
        end
      end
      adv();
    end
  endtask
  task automatic test_jal();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) adv();
      opcode = 6'h03; zero = 1'($urandom); mem_ready = 1'b1;
      #1;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL jal_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL jal_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
      if (c == 2) begin
        vectors++;
        if ({rd_a, m2r_a, rw_a, ps_a, pw_a} !== 8'b10_10_1_10_1) begin fails++; $display("FAIL jal_fields got=%b want=10101101", {rd_a, m2r_a, rw_a, ps_a, pw_a}); end
      end
    end
    adv();
  endtask
  task automatic test_trap();
    logic [31:0] frozen = '0;
    int rb = 0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) adv();
      opcode = 6'h3f; zero = 1'($urandom); mem_ready = 1'b1;
      #1;
      if (c == 2) frozen = ma;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL trap_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL trap_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
      if (c >= 2) begin
        vectors++;
        if ({tr_a, q_a} !== {1'b1, frozen}) begin fails++; $display("FAIL trap_hold got=%h want=%h", {tr_a, q_a}, {1'b1, frozen}); end
      end
      rb += int'(rt_b);
    end
    vectors++;
    if (rb != 0) begin fails++; $display("FAIL nop_retire got=%0d want=0", rb); end
    adv();
    rst = 1'b1;
    #1;
    vectors++;
    if ({oa, ob} !== 38'd0) begin fails++; $display("FAIL trap_rst_outputs got=%h want=0", {oa, ob}); end
    adv();
    rst = 1'b0;
    #1;
    vectors++;
    if ({tr_a, mr_a, q_a} !== {2'b01, 32'd0}) begin fails++; $display("FAIL trap_exit got=%h want=%h", {tr_a, mr_a, q_a}, {2'b01, 32'd0}); end
  endtask
  task automatic test_wrap_abort();
    logic rs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 51; c++) begin
      if (c > 0) adv();
      opcode = 6'h02; zero = 1'($urandom); mem_ready = 1'b1;
      #1;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL wrap_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL wrap_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
    end
    for (int c = 0; c < 5; c++) begin
      adv();
      opcode = 6'h2b; zero = 1'($urandom); mem_ready = rs[c];
      #1;
      if (c == 0) begin
        vectors++;
        if ({q_b, q_a} !== {4'd1, 32'd17}) begin fails++; $display("FAIL wrap_count got=%h want=%h", {q_b, q_a}, {4'd1, 32'd17}); end
      end
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL sw_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL sw_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
    end
    vectors++;
    if ({mw_a, lo_a, rt_a} !== 3'b110) begin fails++; $display("FAIL sw_wait got=%b want=110", {mw_a, lo_a, rt_a}); end
    adv();
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    vectors++;
    if ({oa, ob} !== 38'd0) begin fails++; $display("FAIL sw_rst_outputs got=%h want=0", {oa, ob}); end
    adv();
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    vectors += 3;
    if ({mr_a, mw_a, irw_a} !== 3'b101) begin fails++; $display("FAIL sw_abort_state got=%b want=101", {mr_a, mw_a, irw_a}); end
    if ({q_a, q_b} !== 36'd0) begin fails++; $display("FAIL sw_abort_count got=%h want=0", {q_a, q_b}); end
    if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL sw_abort_a got=%h want=%h", {oa, q_a}, {ea, ma}); end
  endtask
  task automatic test_random();
    logic [5:0] legal [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h06, 6'h09, 6'h0a};
    for (int c = 0; c < 400; c++) begin
      adv();
      if (ph_a == "IF") opcode = legal[$urandom_range(0, 9)];
      zero = 1'($urandom); mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors += 2;
      if ({oa, q_a} !== {ea, ma}) begin fails++; $display("FAIL rand_a ph=%s got=%h want=%h", ph_a, {oa, q_a}, {ea, ma}); end
      if ({ob, q_b} !== {eb, mb}) begin fails++; $display("FAIL rand_b ph=%s got=%h want=%h", ph_b, {ob, q_b}, {eb, mb}); end
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jal();
    test_trap();
    test_wrap_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
